// File: rtl/prf_free_lst_pkg.sv
// Shared rename definitions: physical register file sizing, index/pointer types
// and the ready|index map field used by the issue-queue lines.
package prf_free_lst_pkg;

   localparam int PREG_NUM     = 64;
   localparam int PREG_BITS    = 6;
   localparam int ARCH_REG_NUM = 16;
   localparam int PTR_BITS     = PREG_BITS + 1;

   typedef logic [PREG_BITS-1:0] preg_t;
   typedef logic [PTR_BITS-1:0]  ptr_t;

   typedef struct packed {
      logic  rdy;
      preg_t idx;
   } map_ent_t;

   // The extra wrap bit is what separates a full list from an empty one.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return p + PTR_BITS'(1);
   endfunction

endpackage

// File: rtl/prf_free_lst_if.sv
// Rename-side bundle of the free list: allocate handshake, release/commit/flush
// inputs and occupancy status.
interface prf_free_lst_if;
   import prf_free_lst_pkg::*;

   logic  alloc_req;
   logic  alloc_vld;
   preg_t alloc_preg;
   logic  fre_vld;
   preg_t fre_preg;
   logic  cmt_vld;
   logic  flush;
   ptr_t  free_cnt;
   logic  empty;
   logic  fre_ovf;

   modport master (
      output alloc_req, fre_vld, fre_preg, cmt_vld, flush,
      input  alloc_vld, alloc_preg, free_cnt, empty, fre_ovf
   );

   modport slave (
      input  alloc_req, fre_vld, fre_preg, cmt_vld, flush,
      output alloc_vld, alloc_preg, free_cnt, empty, fre_ovf
   );

endinterface

// File: rtl/prf_fl_ram.sv
// Free-list storage: asynchronous read, synchronous write, reset-loaded with the
// registers that are not architecturally mapped.
module prf_fl_ram
   import prf_free_lst_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  we,
   input  preg_t waddr,
   input  preg_t wdata,
   input  preg_t raddr,
   output preg_t rdata
);

   preg_t mem [PREG_NUM];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PREG_NUM; i++) begin
            mem[i] <= (i < PREG_NUM - ARCH_REG_NUM) ? preg_t'(i + ARCH_REG_NUM) : '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prf_free_lst.sv
// Physical register free list: circular buffer with speculative head, committed
// head and tail pointers; flush rewinds the speculative head in one cycle.
module prf_free_lst
   import prf_free_lst_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   prf_free_lst_if.slave    bus
);

   ptr_t  head;
   ptr_t  cmt_head;
   ptr_t  tail;
   ptr_t  free_cnt;
   preg_t rd_preg;
   logic  fre_ovf;
   logic  full;
   logic  empty;
   logic  alloc_vld;
   logic  alloc_fire;
   logic  rel_fire;
   logic  cmt_fire;

   assign free_cnt   = tail - head;
   assign full       = (free_cnt == ptr_t'(PREG_NUM));
   assign empty      = (free_cnt == '0);
   assign alloc_vld  = !empty && !bus.flush;
   assign alloc_fire = bus.alloc_req && alloc_vld;
   assign rel_fire   = bus.fre_vld && !full;
   assign cmt_fire   = bus.cmt_vld && (cmt_head != head);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head     <= '0;
         cmt_head <= '0;
         tail     <= ptr_t'(PREG_NUM - ARCH_REG_NUM);
         fre_ovf  <= 1'b0;
      end else begin
         // A same-cycle commit survives the flush, so the rewind lands past it.
         if (bus.flush) begin
            head <= cmt_head + ptr_t'(cmt_fire);
         end else if (alloc_fire) begin
            head <= ptr_inc(head);
         end
         if (cmt_fire) begin
            cmt_head <= ptr_inc(cmt_head);
         end
         if (rel_fire) begin
            tail <= ptr_inc(tail);
         end
         if (bus.fre_vld && full) begin
            fre_ovf <= 1'b1;
         end
      end
   end

   prf_fl_ram u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (rel_fire),
      .waddr (tail[PREG_BITS-1:0]),
      .wdata (bus.fre_preg),
      .raddr (head[PREG_BITS-1:0]),
      .rdata (rd_preg)
   );

   assign bus.alloc_vld  = alloc_vld;
   assign bus.alloc_preg = rd_preg;
   assign bus.free_cnt   = free_cnt;
   assign bus.empty      = empty;
   assign bus.fre_ovf    = fre_ovf;

endmodule
